// File: rtl/equiv_sequencer_if.sv
// Bundle of the sweep-control and compare signals of equiv_sequencer.
//   start             sweep request (from master)
//   y_a, y_b          outputs of the two implementations being compared
//   stim              common stimulus vector driven to both implementations
//   busy, done, pass  sweep status and verdict
//   mismatch_cnt      mismatching vectors in the last/current sweep
//   first_fail_valid  a mismatch has been seen in this sweep
//   first_fail_vec    lowest stim value that mismatched
interface equiv_sequencer_if #(
  parameter int N_IN = 3
);
  logic            start;
  logic            y_a;
  logic            y_b;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   mismatch_cnt;
  logic            first_fail_valid;
  logic [N_IN-1:0] first_fail_vec;

  modport slave (
    input  start, y_a, y_b,
    output stim, busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_vec
  );

  modport master (
    output start, y_a, y_b,
    input  stim, busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_vec
  );
endinterface

// File: rtl/equiv_sequencer.sv
// Exhaustive equivalence sequencer: walks stim through every N_IN-bit value,
// holds each vector SETTLE cycles, then compares y_a against y_b for one cycle.
// Reports mismatch count, the first failing vector and a pass/fail verdict.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   eq   equiv_sequencer_if.slave (start, y_a, y_b in; status/results out)
//
// state   | meaning
// IDLE    | waiting for start, results held
// DRIVE   | stim applied, settle counter running
// COMPARE | one cycle: sample y_a/y_b, advance or finish
// DONE    | one cycle: done pulse, verdict published
module equiv_sequencer #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  equiv_sequencer_if.slave  eq
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [N_IN-1:0] STIM_LAST   = '1;
  localparam logic [N_IN-1:0] STIM_ONE    = N_IN'(1);
  localparam logic [N_IN:0]   MC_ONE      = (N_IN+1)'(1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

  state_t          state_q, state_d;
  logic [3:0]      settle_q, settle_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   mc_q, mc_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      stim_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      mc_q     <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      stim_q   <= stim_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      mc_q     <= mc_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (eq.start) state_d = S_DRIVE;
      S_DRIVE:   if (settle_q == SETTLE_LAST) state_d = S_COMPARE;
      S_COMPARE: state_d = (stim_q == STIM_LAST) ? S_DONE : S_DRIVE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    settle_d = settle_q;
    stim_d   = stim_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    mc_d     = mc_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    busy_d   = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (eq.start) begin
          settle_d = '0;
          stim_d   = '0;
          pass_d   = 1'b0;
          mc_d     = '0;
          ffv_d    = 1'b0;
          ffvec_d  = '0;
        end
      end
      S_DRIVE: begin
        settle_d = settle_q + 4'd1;
      end
      S_COMPARE: begin
        if (eq.y_a != eq.y_b) begin
          mc_d = mc_q + MC_ONE;
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = stim_q;
          end
        end
        if (stim_q == STIM_LAST) begin
          // Verdict includes the result of this final compare
          done_d = 1'b1;
          pass_d = (mc_d == '0);
        end else begin
          stim_d   = stim_q + STIM_ONE;
          settle_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign eq.stim             = stim_q;
  assign eq.busy             = busy_q;
  assign eq.done             = done_q;
  assign eq.pass             = pass_q;
  assign eq.mismatch_cnt     = mc_q;
  assign eq.first_fail_valid = ffv_q;
  assign eq.first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_equiv_sequencer.sv
// Self-checking bench for equiv_sequencer (N_IN=3, SETTLE=2).
// y_a is majority(stim); y_b is y_a flipped on vectors selected by fault_mask.
module tb_equiv_sequencer;
  localparam int N_IN   = 3;
  localparam int SETTLE = 2;
  localparam int NVEC   = 1 << N_IN;
  localparam int PER    = SETTLE + 1;
  localparam int LAT    = NVEC * PER;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] fault_mask = 8'h00;
  int         n_cmp = 0;
  int         n_err = 0;

  equiv_sequencer_if #(.N_IN(N_IN)) eq_if ();

  equiv_sequencer #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .eq  (eq_if)
  );

  always #5 clk = ~clk;

  function automatic logic maj(input logic [2:0] s);
    return (s[0] & s[1]) | (s[1] & s[2]) | (s[0] & s[2]);
  endfunction

  always_comb begin
    eq_if.y_a = maj(eq_if.stim);
    eq_if.y_b = maj(eq_if.stim) ^ fault_mask[eq_if.stim];
  end

  // Reference: results of a sweep are determined by which vectors differ
  function automatic int ref_cnt(input logic [7:0] m);
    int n = 0;
    for (int i = 0; i < NVEC; i++) n += int'(m[i]);
    return n;
  endfunction

  function automatic int ref_first(input logic [7:0] m);
    for (int i = 0; i < NVEC; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    eq_if.start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({eq_if.stim, eq_if.busy, eq_if.done, eq_if.pass, eq_if.mismatch_cnt,
         eq_if.first_fail_valid, eq_if.first_fail_vec} !== '0) begin
      n_err++;
      $display("FAIL reset_state: stim=%0d busy=%b done=%b pass=%b mc=%0d ffv=%b ffvec=%0d, want all 0",
               eq_if.stim, eq_if.busy, eq_if.done, eq_if.pass, eq_if.mismatch_cnt,
               eq_if.first_fail_valid, eq_if.first_fail_vec);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One full sweep with start pulsed once; optional extra start at cycle restart_cyc
  task automatic run_sweep(input string name, input logic [7:0] m, input int restart_cyc);
    logic [2:0] exp_stim;
    int         exp_mc;
    int         exp_ff;
    fault_mask = m;
    exp_mc = ref_cnt(m);
    exp_ff = ref_first(m);
    eq_if.start = 1'b1;
    @(negedge clk);
    eq_if.start = 1'b0;
    n_cmp++;
    if (eq_if.stim !== 3'd0 || eq_if.mismatch_cnt !== 4'd0 || eq_if.first_fail_valid !== 1'b0 ||
        eq_if.pass !== 1'b0 || eq_if.busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s_launch: stim=%0d mc=%0d ffv=%b pass=%b busy=%b, want 0 0 0 0 1",
               name, eq_if.stim, eq_if.mismatch_cnt, eq_if.first_fail_valid, eq_if.pass, eq_if.busy);
    end
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      eq_if.start = (c == restart_cyc);
      exp_stim = (c < LAT) ? 3'(c / PER) : 3'(NVEC - 1);
      n_cmp++;
      if (eq_if.done !== (c == LAT)) begin
        n_err++;
        $display("FAIL %s_done_timing: cycle %0d done=%b, want %b", name, c, eq_if.done, c == LAT);
      end
      if (c <= LAT) begin
        n_cmp++;
        if (eq_if.stim !== exp_stim || eq_if.busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s_progress: cycle %0d stim=%0d busy=%b, want %0d 1",
                   name, c, eq_if.stim, eq_if.busy, exp_stim);
        end
      end
      if (c == LAT || c == LAT + 1) begin
        n_cmp++;
        if (eq_if.mismatch_cnt !== 4'(exp_mc) || eq_if.first_fail_valid !== (exp_mc != 0) ||
            eq_if.first_fail_vec !== 3'(exp_ff) || eq_if.pass !== (exp_mc == 0) ||
            eq_if.stim !== 3'd7) begin
          n_err++;
          $display("FAIL %s_result: cycle %0d mc=%0d ffv=%b ffvec=%0d pass=%b stim=%0d, want %0d %b %0d %b 7",
                   name, c, eq_if.mismatch_cnt, eq_if.first_fail_valid, eq_if.first_fail_vec,
                   eq_if.pass, eq_if.stim, exp_mc, exp_mc != 0, exp_ff, exp_mc == 0);
        end
      end
      if (c == LAT + 1) begin
        n_cmp++;
        if (eq_if.busy !== 1'b0) begin
          n_err++;
          $display("FAIL %s_idle_busy: busy=%b, want 0", name, eq_if.busy);
        end
      end
    end
    eq_if.start = 1'b0;
  endtask

  task automatic test_identical();
    run_sweep("identical", 8'h00, -1);
  endtask

  task automatic test_single_fault();
    run_sweep("single_101", 8'b0010_0000, -1);
  endtask

  task automatic test_inverted();
    run_sweep("inverted", 8'hFF, -1);
  endtask

  task automatic test_random();
    logic [7:0] m;
    for (int i = 0; i < 6; i++) begin
      m = 8'($urandom_range(0, 255));
      run_sweep("random", m, -1);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end
  endtask

  task automatic test_restart_ignored();
    int dones = 0;
    // stim is 3'b010 during cycle 2*PER
    run_sweep("restart", 8'b0100_1000, 2 * PER);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (eq_if.done === 1'b1 || eq_if.busy === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL restart_extra_activity: %0d cycles of done/busy after sweep, want 0", dones);
    end
  endtask

  task automatic test_reset_mid();
    int activity = 0;
    fault_mask = 8'b1000_0011;
    eq_if.start = 1'b1;
    @(negedge clk);
    eq_if.start = 1'b0;
    repeat (4 * PER) @(negedge clk);
    n_cmp++;
    if (eq_if.stim !== 3'd4 || eq_if.mismatch_cnt !== 4'd2) begin
      n_err++;
      $display("FAIL rstmid_pre: stim=%0d mc=%0d, want 4 2", eq_if.stim, eq_if.mismatch_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({eq_if.stim, eq_if.busy, eq_if.done, eq_if.pass, eq_if.mismatch_cnt,
         eq_if.first_fail_valid, eq_if.first_fail_vec} !== '0) begin
      n_err++;
      $display("FAIL rstmid_clear: stim=%0d busy=%b done=%b pass=%b mc=%0d ffv=%b ffvec=%0d, want all 0",
               eq_if.stim, eq_if.busy, eq_if.done, eq_if.pass, eq_if.mismatch_cnt,
               eq_if.first_fail_valid, eq_if.first_fail_vec);
    end
    for (int c = 0; c < LAT + 8; c++) begin
      @(negedge clk);
      if (eq_if.done === 1'b1 || eq_if.busy === 1'b1) activity++;
    end
    n_cmp++;
    if (activity != 0) begin
      n_err++;
      $display("FAIL rstmid_no_done: %0d cycles of done/busy after abort, want 0", activity);
    end
    run_sweep("after_rst", 8'b0001_0000, -1);
  endtask

  task automatic test_back_to_back();
    int done_at[3];
    int nd = 0;
    int c = 0;
    fault_mask = 8'h00;
    eq_if.start = 1'b1;
    while (nd < 3 && c < 200) begin
      @(negedge clk);
      c++;
      if (eq_if.done === 1'b1) begin
        done_at[nd] = c;
        nd++;
      end
      if (nd > 0 && c == done_at[nd-1] + 1) begin
        n_cmp++;
        if (eq_if.busy !== 1'b0 || eq_if.pass !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_idle: busy=%b pass=%b, want 0 1", eq_if.busy, eq_if.pass);
        end
      end
      if (nd > 0 && c == done_at[nd-1] + 2) begin
        n_cmp++;
        if (eq_if.busy !== 1'b1 || eq_if.pass !== 1'b0 || eq_if.mismatch_cnt !== 4'd0 ||
            eq_if.stim !== 3'd0) begin
          n_err++;
          $display("FAIL b2b_relaunch: busy=%b pass=%b mc=%0d stim=%0d, want 1 0 0 0",
                   eq_if.busy, eq_if.pass, eq_if.mismatch_cnt, eq_if.stim);
        end
      end
    end
    eq_if.start = 1'b0;
    n_cmp++;
    if (nd != 3) begin
      n_err++;
      $display("FAIL b2b_timeout: saw %0d done pulses, want 3", nd);
    end else begin
      n_cmp++;
      if (done_at[0] != LAT + 1 || done_at[1] - done_at[0] != LAT + 2 ||
          done_at[2] - done_at[1] != LAT + 2) begin
        n_err++;
        $display("FAIL b2b_period: done at %0d,%0d,%0d, want %0d,%0d,%0d",
                 done_at[0], done_at[1], done_at[2], LAT + 1, 2 * LAT + 3, 3 * LAT + 5);
      end
    end
    repeat (LAT + 4) @(negedge clk);
  endtask

  initial begin
    eq_if.start = 1'b0;
    test_reset();
    test_identical();
    test_single_fault();
    test_inverted();
    test_random();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
